// File: rtl/ring_checker_if.sv
// Ring checker bus: the ring counter's load strobe and pattern in, plus the decoded index and health status out.
// The checker uses the slave modport; a driver or monitor uses the master modport.
interface ring_checker_if #(
    parameter int WIDTH  = 4,
    parameter int ERR_W  = 8,
    parameter int WRAP_W = 8
);
    localparam int IDX_W = $clog2(WIDTH);

    logic              set_in;
    logic [WIDTH-1:0]  ring_in;
    logic [IDX_W-1:0]  idx;
    logic              idx_vld;
    logic              locked;
    logic              err;
    logic [ERR_W-1:0]  err_cnt;
    logic [WRAP_W-1:0] wrap_cnt;

    modport master (
        output set_in,
        output ring_in,
        input  idx,
        input  idx_vld,
        input  locked,
        input  err,
        input  err_cnt,
        input  wrap_cnt
    );

    modport slave (
        input  set_in,
        input  ring_in,
        output idx,
        output idx_vld,
        output locked,
        output err,
        output err_cnt,
        output wrap_cnt
    );
endinterface

// File: rtl/ring_checker.sv
// On-line checker and index decoder for a one-hot ring counter; RING_CHECKER_AUTO_SYNC_EN lets any one-hot sample lock.
// Latency: one edge, so every output reflects the sample taken at the previous rising edge.
// Backpressure: none; the checker samples every cycle and cannot stall the ring.
module ring_checker #(
    parameter int               WIDTH  = 4,
    parameter logic [WIDTH-1:0] SEED   = WIDTH'(1),
    parameter int               ERR_W  = 8,
    parameter int               WRAP_W = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    ring_checker_if.slave bus
);
    localparam int IDX_W = $clog2(WIDTH);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t            state_q,    state_d;
    logic              set_q;
    logic [WIDTH-1:0]  prev_q;
    logic [IDX_W-1:0]  idx_q,      idx_d;
    logic              idx_vld_q,  idx_vld_d;
    logic              err_q,      err_d;
    logic [ERR_W-1:0]  err_cnt_q,  err_cnt_d;
    logic [WRAP_W-1:0] wrap_cnt_q, wrap_cnt_d;

    logic [CNT_W-1:0]  ones;
    logic [IDX_W-1:0]  hot_idx;
    logic              onehot;
    logic [WIDTH-1:0]  expected;
    logic              in_seq;
    logic              seed_load;
    logic              rotation;
    logic              lock_ok;

    // Population count and hot-bit position of the current sample.
    always_comb begin
        ones    = '0;
        hot_idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (bus.ring_in[i]) begin
                ones    = ones + CNT_W'(1);
                hot_idx = IDX_W'(i);
            end
        end
    end

    assign onehot    = (ones == CNT_W'(1));
    assign expected  = set_q ? SEED : {prev_q[WIDTH-2:0], prev_q[WIDTH-1]};
    assign in_seq    = (bus.ring_in == expected);
    assign seed_load = set_q && (bus.ring_in == SEED);
    // A load landing on the MSB-to-bit0 step is not a rotation.
    assign rotation  = !set_q && prev_q[WIDTH-1] && bus.ring_in[0];

`ifdef RING_CHECKER_AUTO_SYNC_EN
    assign lock_ok = seed_load || onehot;
`else
    assign lock_ok = seed_load;
`endif

    always_comb begin
        state_d    = state_q;
        err_d      = 1'b0;
        err_cnt_d  = err_cnt_q;
        wrap_cnt_d = wrap_cnt_q;
        idx_d      = onehot ? hot_idx : idx_q;
        idx_vld_d  = onehot;

        unique case (state_q)
            HUNT, FAULT: begin
                if (lock_ok) begin
                    state_d = TRACK;
                end
            end
            TRACK: begin
                if (in_seq) begin
                    if (rotation) begin
                        wrap_cnt_d = wrap_cnt_q + WRAP_W'(1);
                    end
                end else begin
                    state_d = FAULT;
                    err_d   = 1'b1;
                    if (err_cnt_q != {ERR_W{1'b1}}) begin
                        err_cnt_d = err_cnt_q + ERR_W'(1);
                    end
                end
            end
            default: begin
                state_d = HUNT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= HUNT;
            set_q      <= 1'b0;
            prev_q     <= '0;
            idx_q      <= '0;
            idx_vld_q  <= 1'b0;
            err_q      <= 1'b0;
            err_cnt_q  <= '0;
            wrap_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            set_q      <= bus.set_in;
            prev_q     <= bus.ring_in;
            idx_q      <= idx_d;
            idx_vld_q  <= idx_vld_d;
            err_q      <= err_d;
            err_cnt_q  <= err_cnt_d;
            wrap_cnt_q <= wrap_cnt_d;
        end
    end

    assign bus.idx      = idx_q;
    assign bus.idx_vld  = idx_vld_q;
    assign bus.locked   = (state_q == TRACK);
    assign bus.err      = err_q;
    assign bus.err_cnt  = err_cnt_q;
    assign bus.wrap_cnt = wrap_cnt_q;
endmodule

// File: doc/ring_checker.md
Name: ring_checker

Overview:
- Receive-side monitor for a one-hot ring counter bus. Samples the ring counter's `count_out` pattern and its `set_in` load strobe every clock.
- Decodes the hot bit to a binary index, locks onto the rotation sequence and flags any illegal pattern or out-of-sequence step.
- Counts errors and completed rotations. Sits beside any ring counter instance as an on-line checker and index decoder.

Parameters:
- WIDTH, 4, ring width in bits; legal range 2 or more.
- SEED, 1, one-hot load value the ring counter takes on `set_in`; exactly one bit set.
- ERR_W, 8, width of the saturating error counter.
- WRAP_W, 8, width of the wrapping rotation counter.
- IDX_W (localparam), $clog2(WIDTH), index width.

Ports:
- clk  input  1  rising-edge clock, shared with the ring counter.
- rst_n  input  1  reset, synchronous, active-low.
- set_in  input  1  same strobe that drives the ring counter's load; registered internally as set_q.
- ring_in  input  WIDTH  ring counter output.
- idx  output  IDX_W  binary position of the hot bit in the last sample.
- idx_vld  output  1  last sample was exactly one-hot.
- locked  output  1  state == TRACK.
- err  output  1  one-cycle pulse on a detected fault.
- err_cnt  output  ERR_W  saturating count of err pulses.
- wrap_cnt  output  WRAP_W  count of MSB-to-bit0 rotations while locked; wraps modulo 2^WRAP_W.

Behaviour:
- Reset: rst_n sampled low at a rising edge clears the following on that edge:
  - state = HUNT;
  - set_q = 0, prev = 0;
  - idx = 0, idx_vld = 0, locked = 0, err = 0, err_cnt = 0, wrap_cnt = 0.
- Reset mid-operation discards lock and all counts.
- Sampling: every edge with rst_n = 1 samples ring_in. All outputs are registered and reflect the sample taken at that edge (latency 1 edge).
- set_q alignment:
  - set_q = set_in delayed one cycle. This aligns it with the ring counter's loaded value.
  - When set_q = 1, the current sample must equal SEED.
- Pattern checks:
  - onehot = (popcount(ring_in) == 1).
  - idx = index of the set bit when onehot; otherwise idx holds its previous value and idx_vld = 0.
  - expected = SEED if set_q, else rotl(prev, 1) (bit WIDTH-1 moves to bit 0).
- prev is updated to ring_in on every sample.
- HUNT state:
  - If set_q and ring_in == SEED: go to TRACK. No err.
  - Otherwise stay in HUNT. Never raise err.
- TRACK state:
  - If ring_in == expected: stay in TRACK.
  - If set_q == 0, prev[WIDTH-1] == 1 and ring_in[0] == 1: wrap_cnt increments.
  - If ring_in != expected (non-one-hot, skip, reverse step, stall, or wrong load value): go to FAULT, err = 1 for that cycle, err_cnt increments.
- FAULT state:
  - err = 0 after the entry pulse; no further err while in FAULT.
  - If set_q and ring_in == SEED: go to TRACK.
  - Otherwise stay in FAULT. locked = 0.
- Simultaneous events:
  - If set_q arrives while prev is MSB-hot, SEED is expected and wrap_cnt does NOT increment (a load is not a rotation).
  - A load in mid-rotation (prev not SEED) is legal and never an error.
- err_cnt saturates at 2^ERR_W - 1; err still pulses.
- All-zero or multi-hot samples in HUNT or FAULT only drop idx_vld.

Optional Feature:
- Macro RING_CHECKER_AUTO_SYNC_EN.
- Defined: in HUNT and FAULT, any one-hot sample also moves to TRACK on that edge, without needing set_q. The checker self-synchronises to a free-running ring.
- Undefined: only a set_q-qualified SEED sample achieves lock, as described above.

Test Plan:
- Reset: rst_n = 0 for 2 cycles with ring_in = 4'b0101 -> all outputs 0, locked = 0.
- Clean run (WIDTH = 4): set_in = 1 for 1 cycle, then ring 0001,0010,0100,1000,0001 -> locked = 1 from the seed sample, idx 0,1,2,3,0, wrap_cnt = 1, err never asserted.
- Illegal pattern: while locked, drive 0011 -> err = 1 for exactly 1 cycle, idx_vld = 0, locked = 0, err_cnt = 1. Continued correct rotation keeps locked = 0 until set_in re-seeds (macro undefined).
- Skip: locked at 0010, next sample 1000 -> err pulse, err_cnt increments. Then set_in plus 0001 -> locked = 1.
- Mid-rotation load: locked at 0100, set_in = 1, next sample 0001 -> no err, wrap_cnt unchanged. Same load at 1000 -> wrap_cnt unchanged.
- Saturation and auto-sync:
  - ERR_W = 2 with 5 faults -> err_cnt = 3.
  - With RING_CHECKER_AUTO_SYNC_EN, after reset with no set_in, a free-running ring gives locked = 1 on the first one-hot sample.
